// File: rtl/router_1xn_pkt.sv
// rtl/router_1xn_pkt.sv - 1-to-N packet router with per-port FIFOs; parity checking enabled by ROUTER_PARITY_CHECK_EN
module router_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         valid,
    output logic         full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic [CW-1:0] cnt;
    logic          do_push;
    logic          do_pop;

    assign valid   = (cnt != '0);
    assign full    = (cnt == CW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && valid;
    // head is masked when empty so stale storage never reaches the outputs
    assign rdata   = valid ? mem[rp] : '0;

    // storage write; contents need no reset because the head is masked when empty
    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= wdata;
    end

    // pointers wrap naturally; occupancy tracks 0..DEPTH
    always_ff @(posedge clk) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

module router_1xn_pkt #(
    parameter int DW    = 8,
    parameter int N_OUT = 3,
    parameter int DEPTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DW-1:0]       in_data,
    input  logic                in_valid,
    input  logic                in_last,
    output logic                in_ready,
    output logic [N_OUT*DW-1:0] out_data,
    output logic [N_OUT-1:0]    out_valid,
    output logic [N_OUT-1:0]    out_last,
    input  logic [N_OUT-1:0]    out_ready,
    output logic                busy,
    output logic                drop_pulse,
    output logic                parity_err
);
    localparam int AW = $clog2(N_OUT + 1);

    typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

    state_t           state;
    logic [N_OUT-1:0] mask_q;
    logic [N_OUT-1:0] dec_mask;
    logic [N_OUT-1:0] cur_mask;
    logic [N_OUT-1:0] full;
    logic [N_OUT-1:0] push;
    logic [AW-1:0]    addr;
    logic             hdr_valid;
    logic             accept;

    assign addr = in_data[AW-1:0];

    // header decode: all-ones broadcasts, addresses below N_OUT unicast
    always_comb begin
        dec_mask = '0;
        for (int k = 0; k < N_OUT; k++) begin
            if (addr == AW'(k)) dec_mask[k] = 1'b1;
        end
        if (addr == '1) dec_mask = '1;
        hdr_valid = (dec_mask != '0);
    end

    // target ports of the current word and the all-or-nothing space check
    always_comb begin
        cur_mask = '0;
        in_ready = 1'b0;
        case (state)
            IDLE: begin
                cur_mask = dec_mask;
                in_ready = hdr_valid ? ((dec_mask & full) == '0) : 1'b1;
            end
            FWD: begin
                cur_mask = mask_q;
                in_ready = ((mask_q & full) == '0);
            end
            default: in_ready = 1'b1;
        endcase
        if (rst) in_ready = 1'b0;
    end

    assign accept = in_valid && in_ready;
    assign push   = accept ? cur_mask : '0;
    assign busy   = (state != IDLE);

    // packet framing FSM with the drop indication
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            mask_q     <= '0;
            drop_pulse <= 1'b0;
        end else begin
            drop_pulse <= 1'b0;
            if (accept) begin
                case (state)
                    IDLE: begin
                        if (!in_last) begin
                            if (hdr_valid) begin
                                mask_q <= dec_mask;
                                state  <= FWD;
                            end else begin
                                state <= DROP;
                            end
                        end else if (!hdr_valid) begin
                            drop_pulse <= 1'b1;
                        end
                    end
                    FWD: begin
                        if (in_last) state <= IDLE;
                    end
                    default: begin
                        if (in_last) begin
                            state      <= IDLE;
                            drop_pulse <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

`ifdef ROUTER_PARITY_CHECK_EN
    logic [DW-1:0] par_q;

    // running XOR of forwarded words, compared against the closing word
    always_ff @(posedge clk) begin
        if (rst) begin
            par_q      <= '0;
            parity_err <= 1'b0;
        end else begin
            parity_err <= 1'b0;
            if (accept) begin
                if (state == IDLE) begin
                    if (hdr_valid) begin
                        par_q <= in_data;
                        if (in_last && (in_data != '0)) parity_err <= 1'b1;
                    end
                end else if (state == FWD) begin
                    if (in_last) parity_err <= (par_q != in_data);
                    else         par_q      <= par_q ^ in_data;
                end
            end
        end
    end
`else
    assign parity_err = 1'b0;
`endif

    genvar g;
    generate
        for (g = 0; g < N_OUT; g++) begin : g_port
            logic [DW:0] rd;
            router_fifo #(.W(DW + 1), .DEPTH(DEPTH)) u_fifo (
                .clk   (clk),
                .rst   (rst),
                .push  (push[g]),
                .wdata ({in_last, in_data}),
                .pop   (out_ready[g]),
                .rdata (rd),
                .valid (out_valid[g]),
                .full  (full[g])
            );
            assign out_data[g*DW +: DW] = rd[DW-1:0];
            assign out_last[g]          = rd[DW];
        end
    endgenerate
endmodule
